// File: rtl/fir_host_seq_if.sv
// rtl/fir_host_seq_if.sv - host-side coefficient, sample and result streams of the FIR sequencer
interface fir_host_seq_if;
  logic        start_load;
  logic        coef_valid;
  logic [16:0] coef_data;
  logic        coef_ready;
  logic        load_done;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        r_valid;
  logic [15:0] r_data;
  logic        r_ready;

  modport master (
    output start_load, coef_valid, coef_data, s_valid, s_data, r_ready,
    input  coef_ready, load_done, s_ready, r_valid, r_data
  );

  modport slave (
    input  start_load, coef_valid, coef_data, s_valid, s_data, r_ready,
    output coef_ready, load_done, s_ready, r_valid, r_data
  );
endinterface

// File: rtl/fir_host_seq.sv
// rtl/fir_host_seq.sv - turns host ready/valid streams into the FIR core strobe protocol
// Only one sample is in flight; the single buffered result blocks new samples until taken.
module fir_host_seq #(
  parameter int NTAP    = 64,
  parameter int CAW     = 6,
  parameter int TIMEOUT = 255,
  parameter int TOW     = 8
) (
  input  logic           clk1,
  input  logic           rst_n,
  fir_host_seq_if.slave  host,
  output logic [15:0]    fir_din,
  output logic           fir_valid_in,
  output logic [16:0]    fir_cin,
  output logic [CAW-1:0] fir_caddr,
  output logic           fir_cload,
  input  logic [15:0]    fir_dout,
  input  logic           fir_valid,
  output logic           err_timeout,
  output logic           err_spurious,
  output logic           busy
);

  localparam logic [CAW-1:0] LAST_ADDR = CAW'(NTAP - 1);
  localparam logic [TOW-1:0] LAST_TICK = TOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_WAIT} state_t;

  state_t         state;
  logic [CAW-1:0] cnt;
  logic [TOW-1:0] timer;
  logic           fir_valid_q;
  logic           load_done_q;
  logic           r_valid_q;
  logic [15:0]    r_data_q;
  logic           rise;

  assign rise            = fir_valid & ~fir_valid_q;
  assign host.coef_ready = (state == S_LOAD);
  assign host.s_ready    = (state == S_READY) & ~r_valid_q;
  assign host.load_done  = load_done_q;
  assign host.r_valid    = r_valid_q;
  assign host.r_data     = r_data_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      timer        <= '0;
      fir_valid_q  <= 1'b0;
      load_done_q  <= 1'b0;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      fir_din      <= '0;
      fir_valid_in <= 1'b0;
      fir_cin      <= '0;
      fir_caddr    <= '0;
      fir_cload    <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fir_valid_q  <= fir_valid;
      fir_cload    <= 1'b0;
      fir_valid_in <= 1'b0;
      if (r_valid_q && host.r_ready)
        r_valid_q <= 1'b0;

      case (state)
        S_IDLE, S_READY: begin
          if (host.start_load) begin
            state        <= S_LOAD;
            busy         <= 1'b1;
            cnt          <= '0;
            load_done_q  <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
          end else if (state == S_READY && host.s_valid && !r_valid_q) begin
            fir_din      <= host.s_data;
            fir_valid_in <= 1'b1;
            timer        <= '0;
            state        <= S_WAIT;
            busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          if (host.coef_valid) begin
            fir_cin   <= host.coef_data;
            fir_caddr <= cnt;
            fir_cload <= 1'b1;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
              load_done_q <= 1'b1;
              state       <= S_READY;
              busy        <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A result arriving on the final tick beats the timeout.
          if (rise) begin
            r_data_q  <= fir_dout;
            r_valid_q <= 1'b1;
            state     <= S_READY;
            busy      <= 1'b0;
          end else if (timer == LAST_TICK) begin
            err_timeout <= 1'b1;
            state       <= S_READY;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (rise && state != S_WAIT)
        err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_host_seq.sv
// tb/tb_fir_host_seq.sv - randomized bench for fir_host_seq with a transaction-level reference model
module tb_fir_host_seq;
  localparam int NTAP    = 64;
  localparam int TIMEOUT = 255;
  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_WAIT = 3;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fir_din;
  logic        fir_valid_in;
  logic [16:0] fir_cin;
  logic [5:0]  fir_caddr;
  logic        fir_cload;
  logic [15:0] fir_dout = '0;
  logic        fir_valid = 1'b0;
  logic        err_timeout, err_spurious, busy;

  fir_host_seq_if hif ();

  fir_host_seq dut (
    .clk1(clk1), .rst_n(rst_n), .host(hif),
    .fir_din(fir_din), .fir_valid_in(fir_valid_in), .fir_cin(fir_cin),
    .fir_caddr(fir_caddr), .fir_cload(fir_cload), .fir_dout(fir_dout),
    .fir_valid(fir_valid), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int failures = 0;
  int cload_n = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Reference model: mode, count of coefficients accepted, cycles spent waiting.
  int          mode = M_IDLE, pmode, ncoef = 0, elapsed = 0;
  bit          fv_prev = 0, rise, srdy, rv_next;
  bit          e_cload = 0, e_vin = 0, e_done = 0, e_rv = 0, e_eto = 0, e_esp = 0;
  int          e_caddr = 0;
  logic [16:0] e_cin = '0;
  logic [15:0] e_din = '0, e_rdata = '0;

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_IDLE; ncoef = 0; elapsed = 0; fv_prev = 0;
      e_cload = 0; e_vin = 0; e_done = 0; e_rv = 0; e_eto = 0; e_esp = 0;
      e_caddr = 0; e_cin = '0; e_din = '0; e_rdata = '0;
    end else begin
      rise    = fir_valid && !fv_prev;
      fv_prev = fir_valid;
      srdy    = (mode == M_READY) && !e_rv;
      rv_next = e_rv && !hif.r_ready;
      pmode   = mode;
      e_cload = 0;
      e_vin   = 0;
      if ((mode == M_IDLE || mode == M_READY) && hif.start_load) begin
        mode = M_LOAD; ncoef = 0; e_done = 0; e_eto = 0; e_esp = 0;
      end else if (mode == M_READY && hif.s_valid && srdy) begin
        e_vin = 1; e_din = hif.s_data; elapsed = 0; mode = M_WAIT;
      end else if (mode == M_LOAD && hif.coef_valid) begin
        e_cload = 1; e_caddr = ncoef; e_cin = hif.coef_data; ncoef++;
        if (ncoef == NTAP) begin
          e_done = 1; mode = M_READY;
        end
      end else if (mode == M_WAIT) begin
        elapsed++;
        if (rise) begin
          e_rdata = fir_dout; rv_next = 1; mode = M_READY;
        end else if (elapsed == TIMEOUT) begin
          e_eto = 1; mode = M_READY;
        end
      end
      if (rise && pmode != M_WAIT) e_esp = 1;
      e_rv = rv_next;
    end
  end

  always @(negedge clk1) begin
    if (fir_cload === 1'b1) cload_n++;
    if (chk_en) begin
      chk("coef_ready",   32'(hif.coef_ready), 32'(mode == M_LOAD));
      chk("s_ready",      32'(hif.s_ready),    32'(mode == M_READY && !e_rv));
      chk("load_done",    32'(hif.load_done),  32'(e_done));
      chk("fir_cload",    32'(fir_cload),      32'(e_cload));
      chk("fir_caddr",    32'(fir_caddr),      32'(e_caddr));
      chk("fir_cin",      32'(fir_cin),        32'(e_cin));
      chk("fir_valid_in", 32'(fir_valid_in),   32'(e_vin));
      chk("fir_din",      32'(fir_din),        32'(e_din));
      chk("r_valid",      32'(hif.r_valid),    32'(e_rv));
      chk("r_data",       32'(hif.r_data),     32'(e_rdata));
      chk("err_timeout",  32'(err_timeout),    32'(e_eto));
      chk("err_spurious", 32'(err_spurious),   32'(e_esp));
      chk("busy",         32'(busy),           32'(mode == M_LOAD || mode == M_WAIT));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cload"}, 32'(fir_cload), 0);
    chk({tag, "_caddr"}, 32'(fir_caddr), 0);
    chk({tag, "_cin"},   32'(fir_cin), 0);
    chk({tag, "_done"},  32'(hif.load_done), 0);
    chk({tag, "_cready"},32'(hif.coef_ready), 0);
    chk({tag, "_sready"},32'(hif.s_ready), 0);
    chk({tag, "_rvalid"},32'(hif.r_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_errs"},  32'({err_timeout, err_spurious}), 0);
  endtask

  // pat 0: data=i back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic do_load(input int pat, input int abort_at);
    cload_n = 0;
    hif.start_load = 1; step(); hif.start_load = 0;
    chk("load_errs_cleared", 32'({err_timeout, err_spurious}), 0);
    for (int i = 0; i < NTAP; i++) begin
      if (i == abort_at) begin
        rst_n = 0; #1;
        chk_all_zero("midload_rst");
        step(); step(); rst_n = 1; hif.coef_valid = 0; step();
        return;
      end
      if (pat == 1 && i > 0) begin hif.coef_valid = 0; step(); end
      if (pat == 2) repeat ($urandom_range(0, 2)) begin hif.coef_valid = 0; step(); end
      hif.coef_valid = 1;
      hif.coef_data  = (pat == 0) ? 17'(i) : 17'($urandom);
      step();
    end
    chk("last_cload", 32'(fir_cload), 1);
    chk("last_caddr", 32'(fir_caddr), 63);
    chk("last_done",  32'(hif.load_done), 1);
    if (pat == 0) chk("last_cin", 32'(fir_cin), 63);
    hif.coef_valid = 0;
    step();
    chk("cload_cycles", 32'(cload_n), 32'(NTAP));
    chk("ready_after_load", 32'(hif.s_ready), 1);
  endtask

  // dly < 0: the core never answers
  task automatic run_sample(input logic [15:0] d, input int dly, input logic [15:0] dv, input int rwait);
    hif.s_valid = 1; hif.s_data = d; step(); hif.s_valid = 0;
    if (dly < 0) begin
      repeat (TIMEOUT + 5) step();
    end else begin
      repeat (dly) step();
      fir_valid = 1; fir_dout = dv; step(); step(); fir_valid = 0;
      repeat (rwait) step();
      hif.r_ready = 1; step(); hif.r_ready = 0;
    end
  endtask

  initial begin
    hif.start_load = 0; hif.coef_valid = 0; hif.coef_data = '0;
    hif.s_valid = 0; hif.s_data = '0; hif.r_ready = 0;
    repeat (3) @(posedge clk1);
    #1;
    chk_all_zero("reset");
    rst_n = 1; chk_en = 1; step();

    do_load(0, -1);

    hif.s_valid = 1; hif.s_data = 16'h3C00; step(); hif.s_valid = 0;
    chk("vin_pulse", 32'(fir_valid_in), 1);
    chk("din_3c00",  32'(fir_din), 32'h3C00);
    step();
    chk("vin_single", 32'(fir_valid_in), 0);
    repeat (5) step();
    chk("rvalid_before", 32'(hif.r_valid), 0);
    fir_valid = 1; fir_dout = 16'h4000; step();
    chk("rvalid_after_edge", 32'(hif.r_valid), 1);
    chk("rdata_4000", 32'(hif.r_data), 32'h4000);
    step(); fir_valid = 0; step(); step();
    chk("sready_held", 32'(hif.s_ready), 0);
    hif.r_ready = 1; step(); hif.r_ready = 0;
    chk("rvalid_cleared", 32'(hif.r_valid), 0);
    chk("sready_back", 32'(hif.s_ready), 1);

    do_load(1, -1);
    repeat (20) run_sample(16'($urandom), $urandom_range(0, 30), 16'($urandom), $urandom_range(0, 3));

    run_sample(16'h1234, TIMEOUT - 1, 16'h5678, 1);
    chk("edge255_no_timeout", 32'(err_timeout), 0);
    chk("edge255_rdata", 32'(hif.r_data), 32'h5678);

    run_sample(16'h2222, -1, 16'h0, 0);
    chk("timeout_flag", 32'(err_timeout), 1);
    chk("timeout_no_rvalid", 32'(hif.r_valid), 0);
    chk("timeout_ready", 32'(hif.s_ready), 1);

    fir_valid = 1; fir_dout = 16'hBEEF; step(); fir_valid = 0; step();
    chk("spurious_flag", 32'(err_spurious), 1);
    chk("spurious_no_rvalid", 32'(hif.r_valid), 0);

    do_load(2, -1);
    do_load(0, 30);
    do_load(0, -1);
    repeat (8) run_sample(16'($urandom), $urandom_range(0, 12), 16'($urandom), $urandom_range(0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
